beep_burst_gen: RTL
===================

# beep_burst_gen

Burst sequencer that sits directly downstream of the key-driven tone selector. It takes the selected tone clock `clk_sel` as its own clock and emits the beeper drive as timed bursts: `rep_num` bursts of square wave, separated by silent gaps, started by a toggle request from the `sys_clk` domain. All counting is in `clk_sel` cycles, so burst duration scales with the selected tone.

## Interface
- `ON_CYC`, 100: `clk_sel` cycles per burst (≥1).
- `OFF_CYC`, 100: `clk_sel` cycles per silent gap (≥1).
- `CNT_W`, 16: duration counter width; must hold max(`ON_CYC`, `OFF_CYC`).
- `REP_W`, 4: width of the burst-count input.
- `clk_sel`  in  1  block clock (selected tone clock).
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `trig_tgl`  in  1  request toggle from the `sys_clk` domain. Each level change is one request. The source resets it to 0.
- `rep_num`  in  REP_W  number of bursts. Sampled on request acceptance; 0 is treated as 1. Quasi-static.
- `busy`  out  1  high while state ≠ IDLE.
- `bepeer`  out  1  gated square-wave beeper drive.
- `done_tgl`  out  1  toggles once per completed sequence.

## Operation
- **Request synchronizer:** 2-flop synchronizer on `trig_tgl` (`s1`, `s2`), plus history flop `s3`.
  - Request pulse `req = s2 ^ s3`.
  - All three flops reset to 0.
- **FSM states:** IDLE, ON, OFF.
  - **IDLE:**
    - `bepeer` = 0.
    - On `req`: `rep_cnt` ← max(`rep_num`, 1); `cnt` ← 1; `bepeer` ← 1; go to ON.
  - **ON:**
    - `bepeer` toggles every cycle while `cnt` < `ON_CYC`.
    - At `cnt` == `ON_CYC`: `bepeer` ← 0.
      - If `rep_cnt` == 1: go to IDLE and toggle `done_tgl`.
      - Otherwise: `rep_cnt` decrements, `cnt` ← 1, go to OFF.
  - **OFF:**
    - `bepeer` held 0.
    - At `cnt` == `OFF_CYC`: `cnt` ← 1, `bepeer` ← 1, go to ON.
- **Cycle counts:**
  - ON spans exactly `ON_CYC` cycles, with pattern 1,0,1,0,…
  - OFF spans exactly `OFF_CYC` cycles.
  - No trailing gap after the last burst.
- **Sequence length:** N·`ON_CYC` + (N−1)·`OFF_CYC` cycles.
- **Requests while busy:** behaviour set by `BEEP_RETRIG_EN` (see Configuration). `s3` always tracks `s2`, so a request never stays pending.
- **Counter width:** `cnt` saturates nowhere; it is always reloaded before exceeding the limit.
- **Reset mid-operation:** asynchronously forces IDLE. `bepeer` = 0, `busy` = 0, `done_tgl` = 0, `cnt` = 0, `rep_cnt` = 0. No `done_tgl` edge is produced for the aborted sequence.
- **Stopped clock:** when `clk_sel` stops (no key selected), all state and outputs freeze. The sequence resumes when the clock restarts.

## Timing
- Reset values: `busy` 0, `bepeer` 0, `done_tgl` 0.
- Latency, counted from the first `clk_sel` rising edge after the `trig_tgl` change (edge 1):
  - `s2` updates at edge 2.
  - ON entered at edge 3, with `bepeer` = 1 and `busy` = 1 from edge 3.
- `busy` falls on the same edge that `done_tgl` toggles and ON exits.
- `trig_tgl` changes must be spaced ≥3 `clk_sel` cycles apart; closer changes may merge or be lost.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `BEEP_RETRIG_EN`.
- **Defined:** `req` in ON or OFF restarts the sequence.
  - Same actions as from IDLE: reload `rep_cnt` from `rep_num`, `cnt` ← 1, `bepeer` ← 1, state ON.
  - `done_tgl` is not toggled for the abandoned sequence.
- **Undefined:** `req` while `busy` is discarded. The running sequence completes unchanged.

## Test plan
- **Basic two-burst sequence.** `ON_CYC`=4, `OFF_CYC`=3, `rep_num`=2; toggle `trig_tgl`.
  - `busy` rises at edge 3.
  - `bepeer` = 1,0,1,0,0,0,0,1,0,1,0, then 0.
  - `busy` falls after 11 cycles; `done_tgl` toggles exactly once.
- **Zero burst count.** `rep_num`=0; toggle.
  - Exactly one 4-cycle burst (1,0,1,0).
  - `busy` high for 4 cycles; one `done_tgl` edge.
- **Retrigger during gap.** Second toggle delivered so `req` lands in OFF.
  - With `BEEP_RETRIG_EN`: ON re-entered on the next edge and full 2-burst pattern restarts; one `done_tgl` edge total.
  - Without it: original 11-cycle pattern unchanged; one `done_tgl` edge.
- **Reset mid-burst.** Assert `sys_rst_n` low between `clk_sel` edges during ON.
  - `bepeer`, `busy`, `done_tgl` go to 0 immediately.
  - After release, no activity until a new toggle.
- **Stopped clock.** Stop `clk_sel` for 1 ms mid-OFF, then restart.
  - Outputs hold during the stop.
  - Remaining OFF and ON cycles complete with the same counts as uninterrupted.
- **Back-to-back sequences.** Two toggles spaced so the second arrives after `done_tgl`.
  - Two complete identical sequences; `done_tgl` toggles twice and returns to 0.

Source files
------------

// File: rtl/beep_burst_gen.sv
// Burst sequencer clocked by the selected tone clock: emits rep_num square-wave bursts separated by gaps.
// Optional macro BEEP_RETRIG_EN: a request while busy restarts the sequence instead of being dropped.
module beep_burst_gen #(
  parameter int unsigned ON_CYC  = 100,
  parameter int unsigned OFF_CYC = 100,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned REP_W   = 4
) (
  input  logic             clk_sel,
  input  logic             sys_rst_n,
  input  logic             trig_tgl,
  input  logic [REP_W-1:0] rep_num,
  output logic             busy,
  output logic             bepeer,
  output logic             done_tgl
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_CYC);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [REP_W-1:0] r_rep_cnt;
  logic [REP_W-1:0] w_rep_nxt;
  logic             r_bepeer;
  logic             w_bep_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_busy;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_req;
  logic             w_restart;
  logic [REP_W-1:0] w_rep_ld;

  // Toggle-request synchronizer; s3 holds the previous synchronized level
  always_ff @(posedge clk_sel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= trig_tgl;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_req    = r_s2 ^ r_s3;
  assign w_rep_ld = (rep_num == '0) ? REP_ONE : rep_num;

`ifdef BEEP_RETRIG_EN
  assign w_restart = w_req;
`else
  assign w_restart = w_req && (r_state == ST_IDLE);
`endif

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_bep_nxt   = r_bepeer;
    w_done_nxt  = r_done;
    if (w_restart) begin
      w_state_nxt = ST_ON;
      w_cnt_nxt   = CNT_ONE;
      w_rep_nxt   = w_rep_ld;
      w_bep_nxt   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_bep_nxt = 1'b0;
        end
        ST_ON: begin
          if (r_cnt == ON_LIM) begin
            w_bep_nxt = 1'b0;
            if (r_rep_cnt == REP_ONE) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = ~r_done;
            end else begin
              w_rep_nxt   = r_rep_cnt - REP_ONE;
              w_cnt_nxt   = CNT_ONE;
              w_state_nxt = ST_OFF;
            end
          end else begin
            w_bep_nxt = ~r_bepeer;
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_OFF: begin
          w_bep_nxt = 1'b0;
          if (r_cnt == OFF_LIM) begin
            w_cnt_nxt   = CNT_ONE;
            w_bep_nxt   = 1'b1;
            w_state_nxt = ST_ON;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_bep_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // busy is registered alongside the state so every output comes from a flop
  always_ff @(posedge clk_sel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt     <= '0;
      r_rep_cnt <= '0;
      r_bepeer  <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_bepeer  <= w_bep_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign busy     = r_busy;
  assign bepeer   = r_bepeer;
  assign done_tgl = r_done;

endmodule
